// File: rtl/hvac_actuator_ctrl_if.sv
// Request/drive bundle between the AC state machine and the actuator controller.
// HVAC_START_COUNT_EN adds the start_cnt observation bus.
interface hvac_actuator_ctrl_if;
  logic       heat_req;
  logic       cool_req;
  logic       heater_on;
  logic       compressor_on;
  logic       fan_on;
  logic       busy;
  logic       conflict;
`ifdef HVAC_START_COUNT_EN
  logic [7:0] start_cnt;
`endif

  modport master (
`ifdef HVAC_START_COUNT_EN
    input  start_cnt,
`endif
    output heat_req, cool_req,
    input  heater_on, compressor_on, fan_on, busy, conflict
  );

  modport slave (
`ifdef HVAC_START_COUNT_EN
    output start_cnt,
`endif
    input  heat_req, cool_req,
    output heater_on, compressor_on, fan_on, busy, conflict
  );
endinterface

// File: rtl/hvac_actuator_ctrl.sv
// Protected heater/compressor/fan drives: min on/off, heat-cool exclusion, fan overrun; 1-cycle latency, no backpressure.
// HVAC_START_COUNT_EN adds a saturating run-start counter (start_cnt).
module hvac_actuator_ctrl #(
  parameter int MIN_ON   = 8,
  parameter int MIN_OFF  = 8,
  parameter int FAN_TAIL = 4,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hvac_actuator_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HEAT, COOL, LOCKOUT} state_t;

  localparam logic [CNT_W-1:0] MIN_ON_C   = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_C  = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] FAN_TAIL_C = CNT_W'(FAN_TAIL);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] run_cnt, run_nxt;
  logic [CNT_W-1:0] off_cnt, off_nxt;
  logic [CNT_W-1:0] tail_cnt, tail_nxt;
  logic             conflict_nxt;
  logic             start_evt;
  logic             heat_stop, cool_stop;

  assign heat_stop = (!bus.heat_req || bus.cool_req) && (run_cnt >= MIN_ON_C);
  assign cool_stop = (!bus.cool_req || bus.heat_req) && (run_cnt >= MIN_ON_C);

  always_comb begin
    state_nxt    = state;
    run_nxt      = run_cnt;
    off_nxt      = off_cnt;
    tail_nxt     = (tail_cnt == '0) ? '0 : tail_cnt - CNT_ONE;
    conflict_nxt = 1'b0;
    start_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.heat_req && !bus.cool_req) begin
          state_nxt = HEAT;
          run_nxt   = CNT_ONE;
          tail_nxt  = '0;
          start_evt = 1'b1;
        end else if (bus.cool_req && !bus.heat_req) begin
          state_nxt = COOL;
          run_nxt   = CNT_ONE;
          tail_nxt  = '0;
          start_evt = 1'b1;
        end else if (bus.heat_req && bus.cool_req) begin
          conflict_nxt = 1'b1;
        end
      end
      HEAT, COOL: begin
        if ((state == HEAT) ? heat_stop : cool_stop) begin
          state_nxt = LOCKOUT;
          run_nxt   = '0;
          off_nxt   = MIN_OFF_C;
          tail_nxt  = FAN_TAIL_C;
        end else begin
          run_nxt = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_ONE;
        end
      end
      LOCKOUT: begin
        // The edge that takes the off timer to zero is the edge that returns to IDLE.
        if (off_cnt <= CNT_ONE) begin
          state_nxt = IDLE;
          off_nxt   = '0;
        end else begin
          off_nxt = off_cnt - CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      run_cnt           <= '0;
      off_cnt           <= '0;
      tail_cnt          <= '0;
      bus.heater_on     <= 1'b0;
      bus.compressor_on <= 1'b0;
      bus.fan_on        <= 1'b0;
      bus.conflict      <= 1'b0;
    end else begin
      state             <= state_nxt;
      run_cnt           <= run_nxt;
      off_cnt           <= off_nxt;
      tail_cnt          <= tail_nxt;
      bus.heater_on     <= (state_nxt == HEAT);
      bus.compressor_on <= (state_nxt == COOL);
      bus.fan_on        <= (state_nxt == HEAT) || (state_nxt == COOL) || (tail_nxt != '0);
      bus.conflict      <= conflict_nxt;
    end
  end

  assign bus.busy = (state != IDLE);

`ifdef HVAC_START_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.start_cnt <= 8'd0;
    end else if (start_evt && bus.start_cnt != 8'hFF) begin
      bus.start_cnt <= bus.start_cnt + 8'd1;
    end
  end
`endif

endmodule
